spu_issue_ctrl: RTL and testbench

- Dual-issue scheduler between decode and the even/odd pipe pair.
- Accepts one instruction pair (slot0 older, slot1 younger) per handshake.
- Tracks in-flight destination registers with a countdown scoreboard and resolves structural and RAW hazards.
- Drives one registered issue per pipe per cycle. Supports pipe flush and reports a stall count.

---
 rtl/spu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_spu_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_issue_ctrl.sv
// spu_issue_ctrl: dual-issue scheduler between decode and the even/odd pipe
// pair. Buffers one instruction pair, resolves structural and RAW hazards
// against a per-pipe countdown scoreboard, and drives one registered issue
// per pipe per cycle.
module spu_issue_ctrl #(
  parameter int INSTR_W  = 64,
  parameter int SB_DEPTH = 8,
  parameter int LAT_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pair_valid,
  output logic               pair_ready,
  input  logic               s0_valid,
  input  logic               s1_valid,
  input  logic [INSTR_W-1:0] s0_instr,
  input  logic [INSTR_W-1:0] s1_instr,
  input  logic               s0_pipe,
  input  logic               s1_pipe,
  input  logic [6:0]         s0_ra,
  input  logic [6:0]         s0_rb,
  input  logic [6:0]         s0_rc,
  input  logic [6:0]         s1_ra,
  input  logic [6:0]         s1_rb,
  input  logic [6:0]         s1_rc,
  input  logic [2:0]         s0_use,
  input  logic [2:0]         s1_use,
  input  logic [6:0]         s0_rt,
  input  logic [6:0]         s1_rt,
  input  logic               s0_wr,
  input  logic               s1_wr,
  input  logic [LAT_W-1:0]   s0_lat,
  input  logic [LAT_W-1:0]   s1_lat,
  input  logic               flush,
  output logic               ep_valid,
  output logic               op_valid,
  output logic [INSTR_W-1:0] ep_instr,
  output logic [INSTR_W-1:0] op_instr,
  output logic [31:0]        stall_cnt
);

  localparam int IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SPLIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               pipe;
    logic [6:0]         ra;
    logic [6:0]         rb;
    logic [6:0]         rc;
    logic [2:0]         src_use;  // {ra, rb, rc}
    logic [6:0]         rt;
    logic               wr;
    logic [LAT_W-1:0]   lat;
  } slot_t;

  // Pair buffer
  state_t r_state;
  slot_t  r_s0;
  slot_t  r_s1;
  logic   r_s1_pend;

  // Scoreboard, indexed [pipe][entry]
  logic               r_sb_vld [2][SB_DEPTH];
  logic [6:0]         r_sb_rt  [2][SB_DEPTH];
  logic [LAT_W-1:0]   r_sb_cnt [2][SB_DEPTH];

  // Registered outputs
  logic               r_ep_valid;
  logic               r_op_valid;
  logic [INSTR_W-1:0] r_ep_instr;
  logic [INSTR_W-1:0] r_op_instr;
  logic [31:0]        r_stall_cnt;

  slot_t              w_s0_in;
  slot_t              w_s1_in;
  logic               w_s0_blocked;
  logic               w_s1_blocked;
  logic               w_free_any [2];
  logic [IDX_W-1:0]   w_free_idx [2];
  logic               w_s0_ready;
  logic               w_s1_ready;
  logic               w_intra_raw;
  logic               w_waw;
  logic               w_dual;
  logic               w_iss0;
  logic               w_iss1;
  logic               w_last;
  logic               w_pair_ready;
  logic               w_take;

  function automatic logic reads_reg(input slot_t s, input logic [6:0] r);
    return (s.src_use[2] && (s.ra == r)) ||
           (s.src_use[1] && (s.rb == r)) ||
           (s.src_use[0] && (s.rc == r));
  endfunction

  // A latency of 0 is treated as 1, so both start the countdown at 0.
  function automatic logic [LAT_W-1:0] start_cnt(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? '0 : lat - 1'b1;
  endfunction

  assign w_s0_in = '{instr: s0_instr, pipe: s0_pipe, ra: s0_ra, rb: s0_rb, rc: s0_rc,
                     src_use: s0_use, rt: s0_rt, wr: s0_wr, lat: s0_lat};
  assign w_s1_in = '{instr: s1_instr, pipe: s1_pipe, ra: s1_ra, rb: s1_rb, rc: s1_rc,
                     src_use: s1_use, rt: s1_rt, wr: s1_wr, lat: s1_lat};

  // RAW check of both buffered slots against every counting entry of both pipes.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_s0_blocked = 1'b0;
    w_s1_blocked = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (r_sb_vld[p][e] && (r_sb_cnt[p][e] != '0)) begin
          if (reads_reg(r_s0, r_sb_rt[p][e])) w_s0_blocked = 1'b1;
          if (reads_reg(r_s1, r_sb_rt[p][e])) w_s1_blocked = 1'b1;
        end
      end
    end
  end

  // Lowest-numbered free scoreboard entry per pipe.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_free_any[p] = 1'b0;
      w_free_idx[p] = '0;
      for (int e = SB_DEPTH - 1; e >= 0; e--) begin
        if (!r_sb_vld[p][e]) begin
          w_free_any[p] = 1'b1;
          w_free_idx[p] = IDX_W'(e);
        end
      end
    end
  end

  // A writer also needs a free entry in its own pipe.
  assign w_s0_ready  = !w_s0_blocked && (!r_s0.wr || w_free_any[r_s0.pipe]);
  assign w_s1_ready  = !w_s1_blocked && (!r_s1.wr || w_free_any[r_s1.pipe]);

  assign w_intra_raw = r_s0.wr && reads_reg(r_s1, r_s0.rt);
  assign w_waw       = r_s0.wr && r_s1.wr && (r_s0.rt == r_s1.rt);
  assign w_dual      = r_s1_pend && w_s0_ready && w_s1_ready &&
                       (r_s0.pipe != r_s1.pipe) && !w_intra_raw && !w_waw;

  assign w_iss0 = !flush && (r_state == ST_FULL) && w_s0_ready;
  assign w_iss1 = !flush && (((r_state == ST_FULL) && w_dual) ||
                             ((r_state == ST_SPLIT) && w_s1_ready));

  // The last pending slot leaves this cycle, so the buffer can refill at this edge.
  assign w_last = ((r_state == ST_FULL) && w_iss0 && (!r_s1_pend || w_iss1)) ||
                  ((r_state == ST_SPLIT) && w_iss1);

  assign w_pair_ready = !rst && !flush && ((r_state == ST_EMPTY) || w_last);
  assign w_take       = pair_valid && w_pair_ready;

  // Pair buffer FSM: capture, split issue and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_s1_pend <= 1'b0;
      r_s0      <= '0;
      r_s1      <= '0;
    end else if (flush) begin
      r_state   <= ST_EMPTY;
      r_s1_pend <= 1'b0;
    end else if (w_take) begin
      // NOTE: non-blocking assignments, so every register here samples the
      // pre-edge values no matter the statement order.
      r_s0      <= w_s0_in;
      r_s1      <= w_s1_in;
      r_s1_pend <= s1_valid;
      if (s0_valid)      r_state <= ST_FULL;
      else if (s1_valid) r_state <= ST_SPLIT;
      else               r_state <= ST_EMPTY;
    end else if (w_last) begin
      r_state   <= ST_EMPTY;
      r_s1_pend <= 1'b0;
    end else if (w_iss0) begin
      r_state   <= ST_SPLIT;
    end
  end

  // Scoreboard countdown, release and allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is tiny and must read as empty out of reset, so
      // every field is cleared rather than only the valid bits.
      for (int p = 0; p < 2; p++) begin
        for (int e = 0; e < SB_DEPTH; e++) begin
          r_sb_vld[p][e] <= 1'b0;
          r_sb_rt[p][e]  <= '0;
          r_sb_cnt[p][e] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int e = 0; e < SB_DEPTH; e++) begin
          if (r_sb_vld[p][e]) begin
            if (r_sb_cnt[p][e] == '0) r_sb_vld[p][e] <= 1'b0;
            else                      r_sb_cnt[p][e] <= r_sb_cnt[p][e] - 1'b1;
          end
        end
      end
      // Allocations target entries that are currently free, so they never
      // collide with the countdown above; dual issue always uses both pipes.
      if (w_iss0 && r_s0.wr) begin
        r_sb_vld[r_s0.pipe][w_free_idx[r_s0.pipe]] <= 1'b1;
        r_sb_rt[r_s0.pipe][w_free_idx[r_s0.pipe]]  <= r_s0.rt;
        r_sb_cnt[r_s0.pipe][w_free_idx[r_s0.pipe]] <= start_cnt(r_s0.lat);
      end
      if (w_iss1 && r_s1.wr) begin
        r_sb_vld[r_s1.pipe][w_free_idx[r_s1.pipe]] <= 1'b1;
        r_sb_rt[r_s1.pipe][w_free_idx[r_s1.pipe]]  <= r_s1.rt;
        r_sb_cnt[r_s1.pipe][w_free_idx[r_s1.pipe]] <= start_cnt(r_s1.lat);
      end
    end
  end

  // Registered issue to the even and odd pipes; payload holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ep_valid <= 1'b0;
      r_op_valid <= 1'b0;
      r_ep_instr <= '0;
      r_op_instr <= '0;
    end else begin
      r_ep_valid <= (w_iss0 && !r_s0.pipe) || (w_iss1 && !r_s1.pipe);
      r_op_valid <= (w_iss0 &&  r_s0.pipe) || (w_iss1 &&  r_s1.pipe);
      if (w_iss0 && !r_s0.pipe)      r_ep_instr <= r_s0.instr;
      else if (w_iss1 && !r_s1.pipe) r_ep_instr <= r_s1.instr;
      if (w_iss0 && r_s0.pipe)       r_op_instr <= r_s0.instr;
      else if (w_iss1 && r_s1.pipe)  r_op_instr <= r_s1.instr;
    end
  end

  // Saturating count of cycles where a pending slot does not issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ST_EMPTY) && !w_iss0 && !w_iss1 && !flush &&
                 (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pair_ready = w_pair_ready;
  assign ep_valid   = r_ep_valid;
  assign op_valid   = r_op_valid;
  assign ep_instr   = r_ep_instr;
  assign op_instr   = r_op_instr;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// tb_spu_issue_ctrl: directed scenarios plus randomized pairs, all checked
// against a timestamp-based reference model of the issue rules.
module tb_spu_issue_ctrl;

  typedef struct packed {
    logic [63:0] instr;
    logic        pipe;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic [2:0]  use_;
    logic [6:0]  rt;
    logic        wr;
    logic [2:0]  lat;
  } mslot_t;

  // One in-flight write: readers may issue from ready_cyc, entry occupied until free_cyc.
  typedef struct {
    logic [6:0] rt;
    logic       pipe;
    int         ready_cyc;
    int         free_cyc;
  } inflight_t;

  logic        clk = 1'b0;
  logic        rst;
  mslot_t      cur_s0, cur_s1;
  logic        cur_pv, cur_v0, cur_v1, cur_fl;

  logic        pair_ready, ep_valid, op_valid;
  logic [63:0] ep_instr, op_instr;
  logic [31:0] stall_cnt;

  int          n_vec, n_mis;
  int          cyc;
  mslot_t      pend[$];
  inflight_t   infl[$];
  logic [31:0] exp_stall;
  logic        exp_ep_v, exp_op_v;
  logic [63:0] exp_ep_i, exp_op_i;
  logic        got_ready;

  always #5 clk = ~clk;

  spu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .pair_valid(cur_pv), .pair_ready(pair_ready),
    .s0_valid(cur_v0), .s1_valid(cur_v1),
    .s0_instr(cur_s0.instr), .s1_instr(cur_s1.instr),
    .s0_pipe(cur_s0.pipe), .s1_pipe(cur_s1.pipe),
    .s0_ra(cur_s0.ra), .s0_rb(cur_s0.rb), .s0_rc(cur_s0.rc),
    .s1_ra(cur_s1.ra), .s1_rb(cur_s1.rb), .s1_rc(cur_s1.rc),
    .s0_use(cur_s0.use_), .s1_use(cur_s1.use_),
    .s0_rt(cur_s0.rt), .s1_rt(cur_s1.rt),
    .s0_wr(cur_s0.wr), .s1_wr(cur_s1.wr),
    .s0_lat(cur_s0.lat), .s1_lat(cur_s1.lat),
    .flush(cur_fl),
    .ep_valid(ep_valid), .op_valid(op_valid),
    .ep_instr(ep_instr), .op_instr(op_instr),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_reads(input mslot_t s, input logic [6:0] r);
    return (s.use_[2] && s.ra == r) || (s.use_[1] && s.rb == r) || (s.use_[0] && s.rc == r);
  endfunction

  function automatic int m_lat(input mslot_t s);
    return (s.lat == 3'd0) ? 1 : int'(s.lat);
  endfunction

  function automatic bit m_ready(input mslot_t s);
    int occ = 0;
    foreach (infl[i]) begin
      if (m_reads(s, infl[i].rt) && cyc < infl[i].ready_cyc) return 1'b0;
      if (infl[i].pipe == s.pipe && cyc < infl[i].free_cyc) occ++;
    end
    if (s.wr && occ >= 8) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    pend.delete();
    infl.delete();
    exp_stall = '0;
    exp_ep_v  = 1'b0;
    exp_op_v  = 1'b0;
  endtask

  // Decide this cycle's issues from the pending list and in-flight writes.
  task automatic model_eval();
    int     n_iss = 0;
    bit     ready_exp;
    mslot_t s;
    for (int i = infl.size() - 1; i >= 0; i--)
      if (infl[i].free_cyc <= cyc) infl.delete(i);
    if (!cur_fl) begin
      if (pend.size() >= 2 && m_ready(pend[0]) && m_ready(pend[1]) &&
          pend[0].pipe != pend[1].pipe &&
          !(pend[0].wr && m_reads(pend[1], pend[0].rt)) &&
          !(pend[0].wr && pend[1].wr && pend[0].rt == pend[1].rt))
        n_iss = 2;
      else if (pend.size() >= 1 && m_ready(pend[0]))
        n_iss = 1;
    end
    ready_exp = !cur_fl && (pend.size() == 0 || n_iss == pend.size());
    got_ready = pair_ready;
    check("pair_ready", pair_ready, ready_exp);
    if (pend.size() > 0 && n_iss == 0 && !cur_fl && exp_stall != 32'hFFFF_FFFF)
      exp_stall++;
    exp_ep_v = 1'b0;
    exp_op_v = 1'b0;
    for (int k = 0; k < n_iss; k++) begin
      s = pend.pop_front();
      if (s.pipe) begin exp_op_v = 1'b1; exp_op_i = s.instr; end
      else        begin exp_ep_v = 1'b1; exp_ep_i = s.instr; end
      if (s.wr) infl.push_back('{s.rt, s.pipe, cyc + m_lat(s), cyc + m_lat(s) + 1});
    end
    if (cur_fl) pend.delete();
    if (ready_exp && cur_pv) begin
      if (cur_v0) pend.push_back(cur_s0);
      if (cur_v1) pend.push_back(cur_s1);
    end
  endtask

  // One clock: model + pair_ready at negedge, registered outputs after posedge.
  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    cyc++;
    #1;
    check("ep_valid", ep_valid, exp_ep_v);
    check("op_valid", op_valid, exp_op_v);
    if (exp_ep_v) check("ep_instr", ep_instr, exp_ep_i);
    if (exp_op_v) check("op_instr", op_instr, exp_op_i);
    check("stall_cnt", stall_cnt, exp_stall);
  endtask

  task automatic idle(input int n);
    cur_pv = 1'b0;
    cur_fl = 1'b0;
    repeat (n) step();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ep_valid"},   ep_valid,   0);
    check({tag, "_op_valid"},   op_valid,   0);
    check({tag, "_ep_instr"},   ep_instr,   0);
    check({tag, "_op_instr"},   op_instr,   0);
    check({tag, "_stall_cnt"},  stall_cnt,  0);
    check({tag, "_pair_ready"}, pair_ready, 0);
  endtask

  function automatic mslot_t mk(input bit pipe, input int rt, input bit wr, input int lat,
                                input int ra, input logic [2:0] u);
    mslot_t s;
    s.instr = {$urandom, $urandom};
    s.pipe  = pipe;
    s.ra    = 7'(ra);
    s.rb    = 7'd127;
    s.rc    = 7'd127;
    s.use_  = u;
    s.rt    = 7'(rt);
    s.wr    = wr;
    s.lat   = 3'(lat);
    return s;
  endfunction

  function automatic mslot_t rand_slot();
    mslot_t s;
    s.instr = {$urandom, $urandom};
    s.pipe  = 1'($urandom_range(0, 1));
    s.ra    = 7'($urandom_range(0, 7));
    s.rb    = 7'($urandom_range(0, 7));
    s.rc    = 7'($urandom_range(0, 7));
    s.use_  = 3'($urandom_range(0, 7));
    s.rt    = 7'($urandom_range(0, 7));
    s.wr    = ($urandom_range(0, 3) != 0);
    s.lat   = 3'($urandom_range(0, 7));
    return s;
  endfunction

  // Intra-pair RAW across pipes: slot1 follows slot0 by its latency.
  task automatic intra(input int lat, input int exp_gap, input string tag);
    int gap = 0;
    bit seen = 0;
    idle(9);
    cur_s0 = mk(0, 20, 1, lat, 0, 3'b000);
    cur_s1 = mk(1, 21, 0, 1, 20, 3'b100);
    cur_v0 = 1'b1; cur_v1 = 1'b1; cur_pv = 1'b1;
    step();
    cur_pv = 1'b0;
    step();
    check({tag, "_s0_issue"}, ep_valid, 1);
    for (int i = 1; i <= 12 && !seen; i++) begin
      step();
      if (op_valid === 1'b1) begin seen = 1; gap = i; end
    end
    check({tag, "_gap"}, gap, exp_gap);
  endtask

  initial begin
    int          gap;
    bit          seen;
    int          cnt;
    logic [31:0] st0;
    mslot_t      a, b;

    n_vec = 0; n_mis = 0; cyc = 0;
    rst = 1'b1;
    cur_pv = 1'b0; cur_v0 = 1'b0; cur_v1 = 1'b0; cur_fl = 1'b0;
    cur_s0 = '0; cur_s1 = '0;
    exp_ep_i = '0; exp_op_i = '0;
    model_reset();
    #2;
    reset_checks("por");
    #10;
    rst = 1'b0;
    idle(2);

    // Independent dual pair
    a = mk(0, 5, 1, 2, 0, 3'b000);
    b = mk(1, 6, 1, 3, 0, 3'b000);
    cur_s0 = a; cur_s1 = b; cur_v0 = 1'b1; cur_v1 = 1'b1; cur_pv = 1'b1;
    step();
    check("dual_accept_ready", got_ready, 1);
    cur_pv = 1'b0;
    step();
    check("dual_both_valid", {ep_valid, op_valid}, 2'b11);
    check("dual_ep_instr", ep_instr, a.instr);
    check("dual_op_instr", op_instr, b.instr);
    idle(6);

    // Both slots even: serialised, no stall
    a = mk(0, 7, 1, 1, 0, 3'b000);
    b = mk(0, 8, 1, 1, 0, 3'b000);
    cur_s0 = a; cur_s1 = b; cur_v0 = 1'b1; cur_v1 = 1'b1; cur_pv = 1'b1;
    step();
    cur_pv = 1'b0;
    st0 = stall_cnt;
    step();
    check("even_s0", ep_instr, a.instr);
    check("even_s0_v", ep_valid, 1);
    step();
    check("even_s1", ep_instr, b.instr);
    check("even_s1_v", ep_valid, 1);
    check("even_no_stall", stall_cnt - st0, 0);
    idle(4);

    // RAW across pairs, producer lat=6
    cur_s0 = mk(0, 10, 1, 6, 0, 3'b000);
    cur_v0 = 1'b1; cur_v1 = 1'b0; cur_pv = 1'b1;
    step();
    cur_s0 = mk(1, 11, 0, 1, 10, 3'b100);
    step();
    cur_pv = 1'b0;
    check("raw_prod_issue", ep_valid, 1);
    st0 = stall_cnt; gap = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step();
      if (op_valid === 1'b1) begin seen = 1; gap = i; end
    end
    check("raw_gap", gap, 6);
    check("raw_stalls", stall_cnt - st0, 5);

    // Intra-pair dependence
    intra(3, 3, "intra_lat3");
    intra(1, 1, "intra_lat1");
    intra(0, 1, "intra_lat0");

    // Flush while slot1 pending
    idle(9);
    cur_s0 = mk(0, 30, 1, 7, 0, 3'b000);
    cur_s1 = mk(1, 31, 0, 1, 30, 3'b100);
    cur_v0 = 1'b1; cur_v1 = 1'b1; cur_pv = 1'b1;
    step();
    cur_pv = 1'b0;
    step();
    cur_fl = 1'b1;
    step();
    check("flush_ready_low", got_ready, 0);
    cur_fl = 1'b0;
    step();
    check("flush_ready_after", got_ready, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (op_valid === 1'b1) cnt++;
    end
    check("flush_s1_dropped", cnt, 0);

    // Eight lat=7 even writers back-to-back, then a ninth
    idle(9);
    cur_v0 = 1'b1; cur_v1 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cur_s0 = mk(0, 40 + i, 1, 7, 0, 3'b000);
      cur_pv = 1'b1;
      step();
    end
    idle(12);

    // Asynchronous reset in the middle of a transfer
    cur_s0 = mk(0, 50, 1, 3, 0, 3'b000);
    cur_s1 = mk(0, 51, 1, 3, 50, 3'b100);
    cur_v0 = 1'b1; cur_v1 = 1'b1; cur_pv = 1'b1;
    step();
    cur_pv = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    reset_checks("mid");
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      cur_s0 = rand_slot();
      cur_s1 = rand_slot();
      cur_v0 = ($urandom_range(0, 7) != 0);
      cur_v1 = ($urandom_range(0, 7) != 0);
      cur_pv = ($urandom_range(0, 3) != 0);
      cur_fl = ($urandom_range(0, 31) == 0);
      step();
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
